rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Main control FSM for the RV64I multicycle core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath: PC, IR, register file, ALU, ALUOut, MDR, sign-extend/immediate unit and unified memory.
- Drives every datapath enable and mux select, including the immediate-format select consumed by the sign-extend unit.
- Resolves branches from ALU flags. Stalls on a memory ready handshake.

Parameters:
- XLEN, 64, datapath width; informational, no control width depends on it.
- MEM_TIMEOUT, 255, max wait cycles for mem_ready before the memory-error state; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- alu_zero  in  1  ALU result == 0
- alu_lt  in  1  ALU signed less-than flag
- mem_ready  in  1  memory completed the current request
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write, 0 = read
- pc_write  out  1  PC load enable
- pc_old_write  out  1  latch current PC into PC_OLD
- ir_write  out  1  IR load enable
- mdr_write  out  1  MDR load enable
- aluout_write  out  1  ALUOut load enable
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0=PC, 1=rs1, 2=PC_OLD
- alu_src_b  out  2  0=rs2, 1=const 4, 2=imm
- alu_op  out  3  0=ADD, 1=SUB, 2=SLT, 3=SLL, 4=SRL, 5=SRA, 6=func (decode from funct3/funct7b5)
- imm_sel  out  3  0=I, 1=S, 2=SB, 3=U, 4=UJ
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=(rs1+imm)&~1
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (PC+4 already loaded), 3=imm
- halted  out  1  core stopped (break/ebreak or memory error)
- state_dbg  out  5  encoded current state

Behaviour:
- Reset (async, reset_n low): state=FETCH; all enables, mem_req and halted 0; all selects 0. Reset mid-transaction drops mem_req immediately; no write is issued.
- Outputs are Moore-decoded from state, except mem_ready-qualified enables.
- FETCH: mem_req=1, mem_we=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_old_write=1. On mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE. Otherwise hold.
- DECODE: alu_src_a=2, alu_src_b=2, imm_sel=SB, aluout_write=1 (branch target precompute). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 1110011 -> HALT
  - other -> FETCH (treated as NOP)
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=6, aluout_write=1 -> WB_ALU.
- EXEC_I: same as EXEC_R but alu_src_b=2, imm_sel=I -> WB_ALU.
- WB_ALU: reg_write=1, wb_sel=0 -> FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, imm_sel=I (load) or S (store), alu_op=ADD, aluout_write=1. Load -> MEM_RD; store -> MEM_WR.
- MEM_RD: mem_req=1, mem_we=0. On mem_ready: mdr_write=1 -> WB_LOAD.
- MEM_WR: mem_req=1, mem_we=1. On mem_ready -> FETCH.
- WB_LOAD: reg_write=1, wb_sel=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB.
  - taken = funct3 000: alu_zero; 001: !alu_zero; 100: alu_lt; 101: !alu_lt; else 0.
  - If taken: pc_write=1, pc_src=1. Then -> FETCH.
- JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1 -> FETCH. DECODE used imm_sel=SB, so JAL's ALUOut is recomputed: JAL spends one extra cycle in JAL_TGT (alu_src_a=2, alu_src_b=2, imm_sel=UJ, pc_write=1, pc_src=0), then -> FETCH.
  - Final JAL sequence: JAL state does reg_write only -> JAL_TGT -> FETCH.
- JALR: alu_src_a=1, alu_src_b=2, imm_sel=I, reg_write=1, wb_sel=2, pc_write=1, pc_src=2 -> FETCH. Register write uses the pre-update value, because rs1 was read before the PC load.
- LUI: imm_sel=U, reg_write=1, wb_sel=3 -> FETCH.
- HALT: halted=1; no further requests; only reset exits.
- Timeout: a counter runs while mem_req=1 and !mem_ready. Reaching MEM_TIMEOUT -> HALT. The counter clears on every state change.
- mem_ready sampled outside FETCH/MEM_RD/MEM_WR is ignored.

Optional Feature:
- Macro: RV_CTRL_ILLEGAL_TRAP_EN.
- With it defined:
  - Unknown opcodes go to TRAP.
  - TRAP asserts output illegal_instr=1 for one cycle, then -> HALT.
  - illegal_instr is an extra 1-bit output, reset 0.
- Without it: no port and no state; unknown opcodes behave as NOP (DECODE -> FETCH).

Decomposition:
- Package rv_ctrl_pkg holds:
  - state_t enum (5 bits)
  - opcode localparams
  - alu_op_t, imm_sel_t, src_a_t, src_b_t, pc_src_t, wb_sel_t enums
- Sub-module branch_cond: combinational; inputs funct3, alu_zero, alu_lt; output taken.

Test Plan:
- addi 0x00310093, mem_ready immediate: FETCH->DECODE->EXEC_I->WB_ALU = 4 cycles; reg_write for 1 cycle with wb_sel=0; imm_sel=I in EXEC_I.
- lw with mem_ready delayed 3 cycles in MEM_RD: mem_req held 4 cycles with mem_we=0; mdr_write once; reg_write in WB_LOAD; total 8 cycles.
- beq 0x00310263: alu_zero=1 gives pc_write=1 with pc_src=1 in BRANCH; alu_zero=0 gives pc_write=0; bge (funct3=101) with alu_lt=0 is taken.
- jal 0x008000EF: DECODE->JAL (reg_write, wb_sel=2)->JAL_TGT (imm_sel=UJ, pc_write); 4 cycles total.
- Reset asserted mid-MEM_WR: mem_req drops asynchronously; after release, state=FETCH and all enables are 0.
- mem_ready never arrives with MEM_TIMEOUT=8: halted=1 after 8 wait cycles; opcode 1110011 -> halted after DECODE. With the trap macro, opcode 0x7F -> illegal_instr pulse, then halted.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types for the RV64I multicycle control path: state encoding, opcodes,
// datapath select enums and the Moore output decode used by the main FSM.
package rv_ctrl_pkg;

   typedef enum logic [4:0] {
      S_FETCH   = 5'd0,
      S_DECODE  = 5'd1,
      S_EXEC_R  = 5'd2,
      S_EXEC_I  = 5'd3,
      S_WB_ALU  = 5'd4,
      S_ADDR    = 5'd5,
      S_MEM_RD  = 5'd6,
      S_MEM_WR  = 5'd7,
      S_WB_LOAD = 5'd8,
      S_BRANCH  = 5'd9,
      S_JAL     = 5'd10,
      S_JAL_TGT = 5'd11,
      S_JALR    = 5'd12,
      S_LUI     = 5'd13,
      S_HALT    = 5'd14
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      ,
      S_TRAP    = 5'd15
`endif
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_FUNC
   } alu_op_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_SB, IMM_U, IMM_UJ} imm_sel_t;
   typedef enum logic [1:0] {SRC_A_PC, SRC_A_RS1, SRC_A_PC_OLD} src_a_t;
   typedef enum logic [1:0] {SRC_B_RS2, SRC_B_FOUR, SRC_B_IMM} src_b_t;
   typedef enum logic [1:0] {PC_SRC_ALU, PC_SRC_ALUOUT, PC_SRC_JALR} pc_src_t;
   typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC, WB_IMM} wb_sel_t;

   typedef struct packed {
      logic     mem_req;
      logic     mem_we;
      logic     pc_write;
      logic     pc_old_write;
      logic     aluout_write;
      logic     reg_write;
      logic     halted;
      src_a_t   a;
      src_b_t   b;
      alu_op_t  op;
      imm_sel_t imm;
      pc_src_t  pc_src;
      wb_sel_t  wb;
   } ctrl_t;

   // Unconditional outputs of a state; handshake- and flag-qualified enables live in the top.
   function automatic ctrl_t moore_ctrl(input state_t s, input logic is_store);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req = 1'b1; c.pc_old_write = 1'b1; c.b = SRC_B_FOUR;
         end
         S_DECODE: begin
            c.a = SRC_A_PC_OLD; c.b = SRC_B_IMM; c.imm = IMM_SB; c.aluout_write = 1'b1;
         end
         S_EXEC_R: begin
            c.a = SRC_A_RS1; c.b = SRC_B_RS2; c.op = ALU_FUNC; c.aluout_write = 1'b1;
         end
         S_EXEC_I: begin
            c.a = SRC_A_RS1; c.b = SRC_B_IMM; c.imm = IMM_I; c.op = ALU_FUNC;
            c.aluout_write = 1'b1;
         end
         S_WB_ALU:  begin c.reg_write = 1'b1; c.wb = WB_ALUOUT; end
         S_ADDR: begin
            c.a = SRC_A_RS1; c.b = SRC_B_IMM; c.imm = is_store ? IMM_S : IMM_I;
            c.aluout_write = 1'b1;
         end
         S_MEM_RD:  c.mem_req = 1'b1;
         S_MEM_WR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; end
         S_WB_LOAD: begin c.reg_write = 1'b1; c.wb = WB_MDR; end
         S_BRANCH: begin
            c.a = SRC_A_RS1; c.b = SRC_B_RS2; c.op = ALU_SUB; c.pc_src = PC_SRC_ALUOUT;
         end
         S_JAL:     begin c.reg_write = 1'b1; c.wb = WB_PC; end
         S_JAL_TGT: begin
            c.a = SRC_A_PC_OLD; c.b = SRC_B_IMM; c.imm = IMM_UJ; c.pc_write = 1'b1;
            c.pc_src = PC_SRC_ALU;
         end
         S_JALR: begin
            c.a = SRC_A_RS1; c.b = SRC_B_IMM; c.imm = IMM_I; c.reg_write = 1'b1;
            c.wb = WB_PC; c.pc_write = 1'b1; c.pc_src = PC_SRC_JALR;
         end
         S_LUI:     begin c.imm = IMM_U; c.reg_write = 1'b1; c.wb = WB_IMM; end
         S_HALT:    c.halted = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_branch_cond.sv
// Branch resolution from the ALU flags produced by rs1 - rs2.
module branch_cond
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       alu_zero,
   input  logic       alu_lt,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = alu_zero;
         F3_BNE:  taken = ~alu_zero;
         F3_BLT:  taken = alu_lt;
         F3_BGE:  taken = ~alu_lt;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the RV64I multicycle core.
// Optional RV_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap (illegal_instr pulse) then halt.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       alu_zero,
   input  logic       alu_lt,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       pc_write,
   output logic       pc_old_write,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       aluout_write,
   output logic       reg_write,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [2:0] imm_sel,
   output logic [1:0] pc_src,
   output logic [1:0] wb_sel,
   output logic       halted,
   output logic [4:0] state_dbg
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic       illegal_instr
`endif
);

   localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

   state_t      state, nxt;
   ctrl_t       ctl;
   logic [15:0] wait_cnt;
   logic        hs, waiting, timeout, taken;
   logic        unused_inputs;

   // funct7b5 is decoded by the ALU itself when alu_op selects func.
   assign unused_inputs = funct7b5 | (XLEN < 0);

   branch_cond u_branch_cond (
      .funct3   (funct3),
      .alu_zero (alu_zero),
      .alu_lt   (alu_lt),
      .taken    (taken)
   );

   // Handshake uses the registered request, so the bubble cycle after reset never completes one.
   assign hs      = ctl.mem_req & mem_ready;
   assign waiting = ctl.mem_req & ~mem_ready;
   assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_cnt == TMO_LAST);

   always_comb begin
      nxt = state;
      case (state)
         S_FETCH:  if (hs) nxt = S_DECODE; else if (timeout) nxt = S_HALT;
         S_DECODE: begin
            case (opcode)
               OP_R:                nxt = S_EXEC_R;
               OP_I:                nxt = S_EXEC_I;
               OP_LOAD, OP_STORE:   nxt = S_ADDR;
               OP_BRANCH:           nxt = S_BRANCH;
               OP_JAL:              nxt = S_JAL;
               OP_JALR:             nxt = S_JALR;
               OP_LUI:              nxt = S_LUI;
               OP_SYSTEM:           nxt = S_HALT;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
               default:             nxt = S_TRAP;
`else
               default:             nxt = S_FETCH;
`endif
            endcase
         end
         S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
         S_ADDR:   nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: if (hs) nxt = S_WB_LOAD; else if (timeout) nxt = S_HALT;
         S_MEM_WR: if (hs) nxt = S_FETCH; else if (timeout) nxt = S_HALT;
         S_JAL:    nxt = S_JAL_TGT;
         S_WB_ALU, S_WB_LOAD, S_BRANCH, S_JAL_TGT, S_JALR, S_LUI: nxt = S_FETCH;
         S_HALT:   nxt = S_HALT;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:   nxt = S_HALT;
`endif
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_FETCH;
         ctl      <= '0;
         wait_cnt <= '0;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         illegal_instr <= 1'b0;
`endif
      end else begin
         state    <= nxt;
         ctl      <= moore_ctrl(nxt, opcode == OP_STORE);
         wait_cnt <= (nxt != state) ? '0 : (waiting ? wait_cnt + 16'd1 : wait_cnt);
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         illegal_instr <= (nxt == S_TRAP);
`endif
      end
   end

   assign mem_req      = ctl.mem_req;
   assign mem_we       = ctl.mem_we;
   assign pc_old_write = ctl.pc_old_write;
   assign aluout_write = ctl.aluout_write;
   assign reg_write    = ctl.reg_write;
   assign halted       = ctl.halted;
   assign alu_src_a    = ctl.a;
   assign alu_src_b    = ctl.b;
   assign alu_op       = ctl.op;
   assign imm_sel      = ctl.imm;
   assign pc_src       = ctl.pc_src;
   assign wb_sel       = ctl.wb;
   assign ir_write     = (state == S_FETCH) & hs;
   assign mdr_write    = (state == S_MEM_RD) & hs;
   assign pc_write     = ctl.pc_write | ((state == S_FETCH) & hs) | ((state == S_BRANCH) & taken);
   assign state_dbg    = state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized bench for rv_multicycle_ctrl: per-instruction expected control traces
// are built from the instruction class and compared every cycle.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5, alu_zero, alu_lt, mem_ready;
   logic       mem_req, mem_we, pc_write, pc_old_write, ir_write, mdr_write;
   logic       aluout_write, reg_write, halted;
   logic [1:0] alu_src_a, alu_src_b, pc_src, wb_sel;
   logic [2:0] alu_op, imm_sel;
   logic [4:0] state_dbg;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_instr;
`endif

   logic [22:0] obs;
   logic [22:0] exp_q[$];
   logic [2:0]  stim_q[$];
   int n_total = 0;
   int n_bad   = 0;

   localparam logic [7:0] E_REQ = 8'h80, E_WE = 8'h40, E_PCW = 8'h20, E_OLD = 8'h10;
   localparam logic [7:0] E_IR = 8'h08, E_MDR = 8'h04, E_ALUO = 8'h02, E_RW = 8'h01;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   rv_multicycle_ctrl #(.XLEN(64), .MEM_TIMEOUT(8)) dut (
      .clk (clk), .reset_n (reset_n), .opcode (opcode), .funct3 (funct3),
      .funct7b5 (funct7b5), .alu_zero (alu_zero), .alu_lt (alu_lt),
      .mem_ready (mem_ready), .mem_req (mem_req), .mem_we (mem_we),
      .pc_write (pc_write), .pc_old_write (pc_old_write), .ir_write (ir_write),
      .mdr_write (mdr_write), .aluout_write (aluout_write), .reg_write (reg_write),
      .alu_src_a (alu_src_a), .alu_src_b (alu_src_b), .alu_op (alu_op),
      .imm_sel (imm_sel), .pc_src (pc_src), .wb_sel (wb_sel), .halted (halted),
      .state_dbg (state_dbg)
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      , .illegal_instr (illegal_instr)
`endif
   );

   assign obs = {mem_req, mem_we, pc_write, pc_old_write, ir_write, mdr_write,
                 aluout_write, reg_write, alu_src_a, alu_src_b, alu_op, imm_sel,
                 pc_src, wb_sel, halted};

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [22:0] ctl(input int en, input int a, input int b, input int op,
                                       input int imm, input int pcs, input int wb, input int h);
      return {8'(en), 2'(a), 2'(b), 3'(op), 3'(imm), 2'(pcs), 2'(wb), 1'(h)};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l);
      case (f3)
         3'b000:  return z;
         3'b001:  return !z;
         3'b100:  return l;
         3'b101:  return !l;
         default: return 1'b0;
      endcase
   endfunction

   task automatic add(input logic [2:0] stim, input logic [22:0] e);
      stim_q.push_back(stim);
      exp_q.push_back(e);
   endtask

   task automatic fetch_decode(input int wf);
      for (int i = 0; i < wf; i++) add({1'b0, rb(), rb()}, ctl(E_REQ | E_OLD, 0, 1, 0, 0, 0, 0, 0));
      add({1'b1, rb(), rb()}, ctl(E_REQ | E_OLD | E_IR | E_PCW, 0, 1, 0, 0, 0, 0, 0));
      add({rb(), rb(), rb()}, ctl(E_ALUO, 2, 2, 0, 2, 0, 0, 0));
   endtask

   task automatic mem_phase(input int wm, input logic [7:0] en, input logic [7:0] done_en);
      for (int i = 0; i < wm; i++) add({1'b0, rb(), rb()}, ctl(en, 0, 0, 0, 0, 0, 0, 0));
      add({1'b1, rb(), rb()}, ctl(en | done_en, 0, 0, 0, 0, 0, 0, 0));
   endtask

   // cls: 0 R, 1 OP-IMM, 2 load, 3 store, 4 branch, 5 jal, 6 jalr, 7 lui, 8 unknown
   task automatic build(input int cls, input logic [2:0] f3, input int wf, input int wm,
                        input logic z, input logic l, output logic [6:0] op);
      logic [6:0] nop_ops [4];
      nop_ops = '{7'h7F, 7'h00, 7'h0F, 7'h17};
      fetch_decode(wf);
      case (cls)
         0: begin op = 7'b0110011; add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 0, 6, 0, 0, 0, 0));
                  add({rb(), rb(), rb()}, ctl(E_RW, 0, 0, 0, 0, 0, 0, 0)); end
         1: begin op = 7'b0010011; add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 2, 6, 0, 0, 0, 0));
                  add({rb(), rb(), rb()}, ctl(E_RW, 0, 0, 0, 0, 0, 0, 0)); end
         2: begin op = 7'b0000011; add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 2, 0, 0, 0, 0, 0));
                  mem_phase(wm, E_REQ, E_MDR);
                  add({rb(), rb(), rb()}, ctl(E_RW, 0, 0, 0, 0, 0, 1, 0)); end
         3: begin op = 7'b0100011; add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 2, 0, 1, 0, 0, 0));
                  mem_phase(wm, E_REQ | E_WE, 8'h00); end
         4: begin op = 7'b1100011;
                  add({rb(), z, l}, ctl(br_taken(f3, z, l) ? E_PCW : 8'h00, 1, 0, 1, 0, 1, 0, 0)); end
         5: begin op = 7'b1101111; add({rb(), rb(), rb()}, ctl(E_RW, 0, 0, 0, 0, 0, 2, 0));
                  add({rb(), rb(), rb()}, ctl(E_PCW, 2, 2, 0, 4, 0, 0, 0)); end
         6: begin op = 7'b1100111;
                  add({rb(), rb(), rb()}, ctl(E_RW | E_PCW, 1, 2, 0, 0, 2, 2, 0)); end
         7: begin op = 7'b0110111; add({rb(), rb(), rb()}, ctl(E_RW, 0, 0, 0, 3, 0, 3, 0)); end
         default: op = nop_ops[$urandom_range(0, 3)];
      endcase
   endtask

   // ---------------- driver ----------------
   task automatic run(input string tag, input logic [6:0] op, input logic [2:0] f3);
      int n;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (i == 0) begin opcode = op; funct3 = f3; funct7b5 = rb(); end
         {mem_ready, alu_zero, alu_lt} = stim_q.pop_front();
         #1 check(tag, 32'(obs), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic do_reset();
      mem_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1 check("rst_outputs", 32'(obs), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1 check("rst_release", 32'(obs), 32'd0);
   endtask

   task automatic halted_cycles(input int n);
      for (int i = 0; i < n; i++) add({rb(), rb(), rb()}, ctl(0, 0, 0, 0, 0, 0, 0, 1));
   endtask

   // ---------------- stimulus ----------------
   logic [6:0] op;
   logic [2:0] f3;
   int         cls;

   initial begin
      reset_n = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
      alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
      do_reset();

      build(1, 3'b000, 0, 0, 0, 0, op); run("addi", op, 3'b000);
      build(2, 3'b011, 0, 3, 0, 0, op); run("lw_wait3", op, 3'b011);
      build(4, 3'b000, 0, 0, 1, 0, op); run("beq_taken", op, 3'b000);
      build(4, 3'b000, 0, 0, 0, 1, op); run("beq_not_taken", op, 3'b000);
      build(4, 3'b101, 1, 0, 0, 0, op); run("bge_taken", op, 3'b101);
      build(5, 3'b000, 0, 0, 0, 0, op); run("jal", op, 3'b000);
      build(0, 3'b000, 2, 0, 0, 0, op); run("add", op, 3'b000);
      build(3, 3'b011, 0, 1, 0, 0, op); run("sd", op, 3'b011);
      build(6, 3'b000, 0, 0, 0, 0, op); run("jalr", op, 3'b000);
      build(7, 3'b000, 0, 0, 0, 0, op); run("lui", op, 3'b000);
`ifndef RV_CTRL_ILLEGAL_TRAP_EN
      build(8, 3'b000, 0, 0, 0, 0, op); run("unknown_nop", op, 3'b000);
`endif

      // reset while a store is waiting on memory
      fetch_decode(0);
      add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 2, 0, 1, 0, 0, 0));
      for (int i = 0; i < 2; i++) add({1'b0, rb(), rb()}, ctl(E_REQ | E_WE, 0, 0, 0, 0, 0, 0, 0));
      run("sd_pre_reset", 7'b0100011, 3'b011);
      do_reset();

      fetch_decode(1); halted_cycles(3); run("ebreak_halt", 7'b1110011, 3'b000);
      do_reset();

      // fetch never answered: eight wait cycles, then halt
      for (int i = 0; i < 8; i++) add(3'b000, ctl(E_REQ | E_OLD, 0, 1, 0, 0, 0, 0, 0));
      halted_cycles(2); run("fetch_timeout", 7'b0010011, 3'b000);
      do_reset();

      fetch_decode(0);
      add({rb(), rb(), rb()}, ctl(E_ALUO, 1, 2, 0, 0, 0, 0, 0));
      for (int i = 0; i < 8; i++) add(3'b000, ctl(E_REQ, 0, 0, 0, 0, 0, 0, 0));
      halted_cycles(2); run("load_timeout", 7'b0000011, 3'b010);
      do_reset();

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
      fetch_decode(0); run("trap_pre", 7'h7F, 3'b000);
      @(negedge clk); mem_ready = 1'b0;
      #1 check("trap_ctl", 32'(obs), 32'd0);
      check("trap_pulse", 32'(illegal_instr), 32'd1);
      @(negedge clk);
      #1 check("trap_halt", 32'(obs), 32'(ctl(0, 0, 0, 0, 0, 0, 0, 1)));
      check("trap_pulse_end", 32'(illegal_instr), 32'd0);
      do_reset();
`endif

      for (int k = 0; k < 80; k++) begin
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
         cls = $urandom_range(0, 7);
`else
         cls = $urandom_range(0, 8);
`endif
         f3 = 3'($urandom_range(0, 7));
         build(cls, f3, $urandom_range(0, 3), $urandom_range(0, 3), rb(), rb(), op);
         run("random", op, f3);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
